// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encodings and the default operand width.
package serial_sub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused; the next-state logic steers it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_sub_ctrl_pkg

// File: rtl/serial_sub_ctrl_fs_bit.sv
// 1-bit full subtractor: two cascaded half-subtractor stages whose
// borrows are ORed. Computes d = x - y - bin and the borrow out.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First half-subtractor: x - y
    assign hs1_d = x ^ y;
    assign hs1_b = ~x & y;

    // Second half-subtractor: (x - y) - bin
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    assign bout  = hs1_b | hs2_b;

endmodule : fs_bit

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller. One fs_bit cell is stepped
// LSB-first over WIDTH cycles with the borrow held in a flop. Results and
// flags are registered and hold until the next completed operation.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sb_q;
    // Only WIDTH-1 result bits are stored; the final bit from the cell
    // completes the word on the edge that enters DONE.
    logic [WIDTH-2:0]   res_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               a_sign_q, b_sign_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_out_q, zero_q, ovf_q;

    logic               cell_d, cell_bo;
    logic [WIDTH-1:0]   res_next;
    logic               last_bit;

    fs_bit u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign res_next = {cell_d, res_q};
    assign last_bit = (cnt_q == CNT_LAST);

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after WIDTH bits.
    always_comb begin
        // NOTE: assign a default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Datapath: operand capture, serial shift, and result/flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        a_sign_q <= a[WIDTH-1];
                        b_sign_q <= b[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    res_q    <= res_next[WIDTH-1:1];
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    borrow_q <= cell_bo;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        diff_q       <= res_next;
                        borrow_out_q <= cell_bo;
                        zero_q       <= (res_next == '0);
                        ovf_q        <= (a_sign_q != b_sign_q) && (cell_d != a_sign_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH = 8): directed cases,
// randomized operands against an arithmetic reference model, start-held
// throughput, and mid-operation reset abort.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow_out, zero, ovf;
    logic [W-1:0] diff;

    int total  = 0;
    int passes = 0;

    logic [W-1:0] prev_diff = '0;
    logic         prev_borrow = 1'b0, prev_zero = 1'b0, prev_ovf = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] ed, output logic eb,
                         output logic ez, output logic eo);
        int ua, ub, sa, sb, sd;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sd = sa - sb;
        ed = W'(ua - ub);
        eb = (ua < ub);
        ez = (ed == '0);
        eo = (sd > 127) || (sd < -128);
    endtask

    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input string tag);
        logic [W-1:0] ed;
        logic eb, ez, eo;
        int lat;
        model(op_a, op_b, ed, eb, ez, eo);
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".done_early"}, done, 0);
        check({tag, ".diff_held"}, diff, prev_diff);
        check({tag, ".zero_held"}, zero, prev_zero);
        lat = 0;
        while (done !== 1'b1 && lat < 3 * W) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, W);
        check({tag, ".diff"}, diff, ed);
        check({tag, ".borrow"}, borrow_out, eb);
        check({tag, ".zero"}, zero, ez);
        check({tag, ".ovf"}, ovf, eo);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".idle"}, busy, 0);
        check({tag, ".diff_hold"}, diff, ed);
        prev_diff = ed; prev_borrow = eb; prev_zero = ez; prev_ovf = eo;
    endtask

    initial begin
        int pulses, last_k, wait_n;

        // Reset state
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.diff", diff, 0);
        check("rst.flags", {borrow_out, zero, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'd5,  8'd3,  "d_5m3");
        run_op(8'd3,  8'd5,  "d_3m5");
        run_op(8'h80, 8'h01, "d_80m01");
        run_op(8'h7F, 8'hFF, "d_7Fm FF");
        run_op(8'h2A, 8'h2A, "d_eq");
        run_op(8'h00, 8'h00, "d_zero");
        run_op(8'hFF, 8'h00, "d_ff");

        // Randomized operands, with some equal pairs
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 6 == 0) ? ra : W'($urandom);
            run_op(ra, rb, $sformatf("rnd%0d", i));
        end

        // Start held high: one done per W+2 cycles; mid-op change of a ignored
        @(negedge clk);
        a = 8'h2A; b = 8'h2A; start = 1'b1;
        @(negedge clk);
        pulses = 0;
        last_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3) a = 8'h11;
            if (k == 5) a = 8'h2A;
            if (done === 1'b1) begin
                check($sformatf("hold.diff@%0d", k), diff, 0);
                check($sformatf("hold.zero@%0d", k), zero, 1);
                if (last_k < 0) check("hold.first", k, W);
                else            check($sformatf("hold.period@%0d", k), k - last_k, W + 2);
                pulses++;
                last_k = k;
            end
        end
        check("hold.pulses", pulses, 4);
        start = 1'b0;
        wait_n = 0;
        while (busy !== 1'b0 && wait_n < 30) begin
            @(negedge clk);
            wait_n++;
        end
        check("hold.drain", busy, 0);
        prev_diff = '0; prev_borrow = 1'b0; prev_zero = 1'b1; prev_ovf = 1'b0;

        // Reset asserted mid-operation aborts with no done pulse
        @(negedge clk);
        a = 8'd9; b = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.diff", diff, 0);
        check("abort.flags", {borrow_out, zero, ovf}, 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0) pulses++;
        end
        check("abort.no_done", pulses, 0);
        prev_diff = '0; prev_borrow = 1'b0; prev_zero = 1'b0; prev_ovf = 1'b0;
        run_op(8'd9, 8'd4, "post_rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_serial_sub_ctrl

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit subtractor controller: sequences a single 1-bit subtract cell LSB-first over WIDTH cycles, holding the borrow between bits.
- Computes diff = a - b with borrow, zero and signed-overflow flags.
- Used as a low-area SUB/compare unit beside the ALU, e.g. for multi-cycle SUB/SLT and beq/bne zero test.
- Uses a start/busy/done handshake toward the issuing control unit.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start
- b  input  WIDTH  subtrahend; captured on the accepted start
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; results valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow_out  output  1  1 when unsigned a < b
- zero  output  1  1 when diff == 0
- ovf  output  1  signed two's-complement overflow of a - b

Behaviour:
- Reset (async assert, sync-free release) drives the following:
  - state = IDLE
  - busy, done, diff, borrow_out, zero and ovf all 0
  - internal shift registers, borrow flop and bit counter all 0
- All outputs are registered; there are no combinational paths from input to output.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start = 1 at an edge loads sa <= a, sb <= b, borrow <= 0, cnt <= 0.
  - The same edge latches the sign bits a[WIDTH-1] and b[WIDTH-1] and moves to SHIFT.
  - start = 0 keeps the FSM in IDLE.
- SHIFT, each edge:
  - The cell computes d = sa[0] ^ sb[0] ^ borrow and bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - Result register: res <= {d, res[WIDTH-1:1]}.
  - Operand registers: sa <= sa >> 1 and sb <= sb >> 1.
  - Borrow and counter: borrow <= bo and cnt <= cnt + 1.
  - When cnt == WIDTH-1 at the edge, go to DONE.
- DONE, lasting exactly one cycle:
  - done = 1 and the outputs are updated as follows:
    - diff = res
    - borrow_out = final borrow
    - zero = (res == 0)
    - ovf = (a_sign != b_sign) & (res[WIDTH-1] != a_sign)
  - The next edge returns to IDLE.
- Latency: with start accepted at edge E0, shifts occur on E1..E_WIDTH and done is high from E_WIDTH until E_WIDTH+1.
  - For WIDTH = 8 this means done is high 8 cycles after acceptance.
  - Throughput is one operation per WIDTH+2 cycles.
- diff and the flags hold their values until the next DONE or reset. They do not clear on a new start.
- start while busy (SHIFT or DONE) is ignored and not queued. Changes to a and b after acceptance have no effect.
- Counter width is $clog2(WIDTH). Wrap is impossible because the FSM leaves SHIFT at WIDTH-1.
- rst_n asserted mid-operation aborts immediately to the reset values, with no done pulse.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- One sub-module, fs_bit: a 1-bit full subtractor built from two half-subtractor cells plus an OR on the borrows.
  - Ports: x, y, bin, d, bout.
  - serial_sub_ctrl instantiates it once as the shared datapath cell.

Test Plan (WIDTH = 8):
- a = 8'd5, b = 8'd3, start pulsed for 1 cycle -> busy = 1 next cycle; done pulse 8 cycles after acceptance with diff = 8'h02, borrow_out = 0, zero = 0, ovf = 0.
- a = 8'd3, b = 8'd5 -> diff = 8'hFE, borrow_out = 1, zero = 0, ovf = 0.
- a = 8'h80, b = 8'h01 -> diff = 8'h7F, borrow_out = 0, ovf = 1. Then a = 8'h7F, b = 8'hFF -> diff = 8'h80, borrow_out = 1, ovf = 1.
- a = 8'h2A, b = 8'h2A -> diff = 8'h00, zero = 1, borrow_out = 0. Then, with start held high continuously: start ignored while busy, so exactly one done pulse per WIDTH+2 cycles; a changed mid-operation leaves the result unaffected.
- Start 8'd9 - 8'd4, then assert rst_n = 0 at shift 4 -> all outputs 0 immediately, no done pulse. After release, a new start of 8'd9 - 8'd4 gives diff = 8'h05.
